// File: rtl/vga_timing_drv.sv
// ============================================================================
// Module   : vga_timing_drv
// Purpose  : 800x600@72 raster timing generator and registered pixel sink.
//            Optional colour-bar source enabled by VGA_TEST_PATTERN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_drv #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] vga_data,
    input  logic        pattern_sel,
    output logic [9:0]  vga_xide,
    output logic [9:0]  vga_yide,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [23:0] vga_rgb,
    output logic        frame_start
);

    localparam logic [10:0] c_h_act  = 11'(H_ACTIVE);
    localparam logic [10:0] c_hs_beg = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_hs_end = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_h_last = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  c_v_act  = 10'(V_ACTIVE);
    localparam logic [9:0]  c_vs_beg = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  c_vs_end = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  c_v_last = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [10:0] r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic        w_act;
    logic        w_hsync;
    logic        w_vsync;
    logic [23:0] w_pix;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 11'd1;
        end
    end

    assign w_act    = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
    assign w_hsync  = (r_h_cnt >= c_hs_beg) && (r_h_cnt < c_hs_end);
    assign w_vsync  = (r_v_cnt >= c_vs_beg) && (r_v_cnt < c_vs_end);
    assign vga_xide = w_act ? r_h_cnt[9:0] : '0;
    assign vga_yide = w_act ? r_v_cnt : '0;

`ifdef VGA_TEST_PATTERN_EN
    logic [23:0] w_bar;

    // Bar index is x/100, resolved as a compare ladder rather than a divider.
    always_comb begin
        w_bar = 24'h000000;
        if      (vga_xide < 10'd100) w_bar = 24'hFFFFFF;
        else if (vga_xide < 10'd200) w_bar = 24'h00FFFF;
        else if (vga_xide < 10'd300) w_bar = 24'hFFFF00;
        else if (vga_xide < 10'd400) w_bar = 24'h00FF00;
        else if (vga_xide < 10'd500) w_bar = 24'hFF00FF;
        else if (vga_xide < 10'd600) w_bar = 24'h0000FF;
        else if (vga_xide < 10'd700) w_bar = 24'hFF0000;
        else                         w_bar = 24'h000000;
    end

    assign w_pix = pattern_sel ? w_bar : vga_data;
`else
    logic w_unused;

    assign w_unused = pattern_sel;
    assign w_pix    = vga_data;
`endif

    // Single output stage keeps rgb, de, syncs and frame_start aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vga_de      <= 1'b0;
            vga_rgb     <= '0;
            vga_hs      <= ~SYNC_POL;
            vga_vs      <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            vga_de      <= w_act;
            vga_rgb     <= w_act ? w_pix : '0;
            vga_hs      <= w_hsync ? SYNC_POL : ~SYNC_POL;
            vga_vs      <= w_vsync ? SYNC_POL : ~SYNC_POL;
            frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
        end
    end

endmodule

`default_nettype wire
